pie_rx_gen2: RTL and testbench
==============================

Name: pie_rx_gen2

Overview:
Parametrised Gen2 PIE receive decoder; the next generation of the tag front-end RX.
- Converts the demodulated reader envelope into a serial bit stream with a one-cycle valid strobe.
- Measures Tari (data-0), RTcal and TRcal.
- Distinguishes a full preamble (Query) from a frame-sync, and signals end-of-frame and framing errors.
- Sits between the analog demodulator and the command parser; trcal feeds TX clock calibration.

Parameters:
CNT_W, 10, width of interval counter and of all measured-interval outputs.
FILT_LEN, 2, consecutive equal samples of demodin needed to accept a level change (min 1).
DELIM_MIN, 8, minimum delimiter low time in clocks; shorter lows are ignored as glitches.

Ports:
clk  in  1  single system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
demodin  in  1  raw demodulated envelope, asynchronous to clk; idle high.
bit_out  out  1  decoded data bit; valid when bit_valid=1.
bit_valid  out  1  one-cycle strobe per decoded bit.
preamble  out  1  1 = current frame began with TRcal (Query); 0 = frame-sync.
tari  out  CNT_W  measured data-0 interval.
rtcal  out  CNT_W  measured RTcal interval.
trcal  out  CNT_W  measured TRcal interval (holds last value if frame-sync).
rx_overflow_reset  out  1  one-cycle end-of-frame pulse.
frame_err  out  1  one-cycle framing-error pulse.
rng_bit  out  1  LSB of the most recently captured interval (entropy source).
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs and registers 0; state IDLE; filtered level = 1. Reset mid-frame aborts the frame with no pulses.
- Input path: 2-flop synchroniser, then FILT_LEN-sample filter. Rising/falling edge is flagged in the cycle the filtered level changes.
- Interval counter cnt: on a rising-edge cycle, captured = cnt and cnt <= 1; otherwise cnt <= cnt+1, saturating at all-ones. The captured value equals the clocks between consecutive filtered rising edges. In DELIM, cnt counts low time from the falling edge.
- IDLE: filtered falling edge -> DELIM, cnt <= 1.
- DELIM:
  - Rising edge with cnt >= DELIM_MIN -> DATA0, cnt <= 1.
  - Rising edge with cnt < DELIM_MIN -> IDLE, no error.
- DATA0: rising edge -> tari <= captured; go RTCAL.
- RTCAL: rising edge ->
  - captured <= tari: frame_err pulse, go IDLE.
  - Otherwise: rtcal <= captured; go TRCAL.
- TRCAL: rising edge ->
  - captured > rtcal: trcal <= captured; preamble <= 1; go BITS.
  - Otherwise: preamble <= 0; the interval is the first data bit, decoded as in BITS; go BITS.
- BITS: rising edge -> bit_out <= (captured > rtcal>>1), strict compare; bit_valid pulses in the same registered cycle (one cycle after edge detect).
- End of frame: in BITS, when cnt > rtcal -> rx_overflow_reset pulses for one cycle; go IDLE.
- Counter saturation in DELIM/DATA0/RTCAL/TRCAL -> frame_err pulse, go IDLE.
- Edge and end-of-frame in the same cycle: the edge wins (bit decoded, stays in BITS).
- rng_bit <= captured[0] on every captured rising edge, in any state except IDLE.
- Latency: raw demodin change to filtered edge = 2 + FILT_LEN clocks; edge to bit_valid = 1 clock.
- bit_valid, rx_overflow_reset and frame_err are mutually exclusive in any cycle.

Decomposition:
- Package pie_rx_pkg: state enum (IDLE, DELIM, DATA0, RTCAL, TRCAL, BITS) and default constants for CNT_W, FILT_LEN, DELIM_MIN.
- Sub-module pie_rx_filter(FILT_LEN): synchroniser, glitch filter and rise/fall edge flags.
- Counter and FSM stay in the top module.

Test Plan:
Clock-count intervals below are measured on the filtered signal; FILT_LEN=2, DELIM_MIN=8 unless stated.
- Query preamble: delimiter 12 low, intervals 20, 50, 100, then bits 20, 35, 25 -> tari=20, rtcal=50, trcal=100, preamble=1; bits 0,1,0 (25 = pivot -> 0); rx_overflow_reset exactly 51 clocks after last edge.
- Frame-sync: delimiter 12, intervals 20, 50, 30 -> preamble=0; first bit 1 emitted from the TRCAL slot; trcal keeps its prior value.
- Glitches: 1-clock low pulse on idle line -> no state change, busy=0. 5-clock low (< DELIM_MIN) -> back to IDLE, no frame_err.
- Bad RTcal: intervals 20 then 18 -> frame_err single pulse; returns to IDLE; rtcal unchanged.
- Saturation: CNT_W=6, line held high 70 clocks in DATA0 -> frame_err at count 63, IDLE.
- Reset asserted mid-BITS -> next cycle all outputs 0, state IDLE, no rx_overflow_reset pulse.

Source files
------------

// File: rtl/pie_rx_pkg.sv
// pie_rx_pkg: shared state encoding and default parameters for the Gen2 PIE receiver.
package pie_rx_pkg;
    typedef enum logic [2:0] {IDLE, DELIM, DATA0, RTCAL, TRCAL, BITS} state_e;
    localparam int CNT_W_DEF     = 10;
    localparam int FILT_LEN_DEF  = 2;
    localparam int DELIM_MIN_DEF = 8;
endpackage

// File: rtl/pie_rx_filter.sv
// pie_rx_filter: two-flop synchroniser, FILT_LEN-sample glitch filter and edge flags.
module pie_rx_filter #(
    parameter int FILT_LEN = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic demod_i,
    output logic rise_o,
    output logic fall_o
);
    localparam int FW = $clog2(FILT_LEN + 1);
    logic          sync1_q, sync2_q, level_q, rise_q, fall_q;
    logic [FW-1:0] run_q;
    logic          hit;
    assign hit = (sync2_q != level_q) && (run_q == FW'(FILT_LEN - 1));
    // The line idles high, so the synchroniser starts high to avoid a false falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            run_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= demod_i;
            sync2_q <= sync1_q;
            run_q   <= (sync2_q != level_q && !hit) ? run_q + 1'b1 : '0;
            level_q <= hit ? sync2_q : level_q;
            rise_q  <= hit & sync2_q;
            fall_q  <= hit & ~sync2_q;
        end
    end
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/pie_rx_gen2.sv
// pie_rx_gen2: Gen2 PIE receive decoder; measures Tari/RTcal/TRcal and emits decoded bits
// with end-of-frame and framing-error pulses.
module pie_rx_gen2
    import pie_rx_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FILT_LEN  = FILT_LEN_DEF,
    parameter int DELIM_MIN = DELIM_MIN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             demodin,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             preamble,
    output logic [CNT_W-1:0] tari,
    output logic [CNT_W-1:0] rtcal,
    output logic [CNT_W-1:0] trcal,
    output logic             rx_overflow_reset,
    output logic             frame_err,
    output logic             rng_bit,
    output logic             busy
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, tari_q, tari_d, rtcal_q, rtcal_d, trcal_q, trcal_d;
    logic             bit_q, bit_d, bv_q, bv_d, pre_q, pre_d;
    logic             eof_q, eof_d, err_q, err_d, rng_q, rng_d;
    logic             rise, fall, sat, bit_dec;

    pie_rx_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk    (clk),
        .reset  (reset),
        .demod_i(demodin),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign sat     = cnt_q == CNT_MAX;
    assign bit_dec = cnt_q > (rtcal_q >> 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = rise ? CNT_ONE : (sat ? cnt_q : cnt_q + 1'b1);
        tari_d  = tari_q;
        rtcal_d = rtcal_q;
        trcal_d = trcal_q;
        pre_d   = pre_q;
        bit_d   = bit_q;
        bv_d    = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;
        rng_d   = (rise && state_q != IDLE) ? cnt_q[0] : rng_q;
        case (state_q)
            IDLE: begin
                state_d = fall ? DELIM : IDLE;
                cnt_d   = fall ? CNT_ONE : cnt_d;
            end
            DELIM: if (rise) state_d = (cnt_q >= CNT_W'(DELIM_MIN)) ? DATA0 : IDLE;
            DATA0: if (rise) begin
                tari_d  = cnt_q;
                state_d = RTCAL;
            end
            RTCAL: if (rise) begin
                err_d   = cnt_q <= tari_q;
                rtcal_d = err_d ? rtcal_q : cnt_q;
                state_d = err_d ? IDLE : TRCAL;
            end
            TRCAL: if (rise) begin
                pre_d   = cnt_q > rtcal_q;
                trcal_d = pre_d ? cnt_q : trcal_q;
                bit_d   = pre_d ? bit_q : bit_dec;
                bv_d    = !pre_d;
                state_d = BITS;
            end
            BITS: if (rise) begin
                bit_d = bit_dec;
                bv_d  = 1'b1;
            end else if (cnt_q > rtcal_q || sat) begin
                eof_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A calibration interval that never ends is a framing error.
        if (!rise && sat && state_q inside {DELIM, DATA0, RTCAL, TRCAL}) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tari_q  <= '0;
            rtcal_q <= '0;
            trcal_q <= '0;
            pre_q   <= 1'b0;
            bit_q   <= 1'b0;
            bv_q    <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tari_q  <= tari_d;
            rtcal_q <= rtcal_d;
            trcal_q <= trcal_d;
            pre_q   <= pre_d;
            bit_q   <= bit_d;
            bv_q    <= bv_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
            rng_q   <= rng_d;
        end
    end

    assign bit_out           = bit_q;
    assign bit_valid         = bv_q;
    assign preamble          = pre_q;
    assign tari              = tari_q;
    assign rtcal             = rtcal_q;
    assign trcal             = trcal_q;
    assign rx_overflow_reset = eof_q;
    assign frame_err         = err_q;
    assign rng_bit           = rng_q;
    assign busy              = state_q != IDLE;
endmodule

// File: tb/tb_pie_rx_gen2.sv
// tb_pie_rx_gen2: directed frames checked against a frame-level scoreboard model.
module tb_pie_rx_gen2;
    localparam int PW = 4;
    typedef struct {int kind; int b; int ta; int rt; int tr; int pre;} ev_t;

    logic       clk = 1'b0, reset = 1'b1, demodin = 1'b1;
    logic       bit_out, bit_valid, preamble, rx_overflow_reset, frame_err, rng_bit, busy;
    logic [9:0] tari, rtcal, trcal;
    logic       bo6, bv6, pr6, eof6, err6, rng6, busy6;
    logic [5:0] ta6, rt6, tr6;
    int         n_vec = 0, n_err = 0, cyc = 0, bv_cyc = 0, last_gap = -1;
    int         m_ta = 0, m_rt = 0, m_tr = 0, m_pre = 0;
    ev_t        exp_q[$];
    int         iv_q[$];
    int         bit_log[$];

    pie_rx_gen2 dut (
        .clk(clk), .reset(reset), .demodin(demodin), .bit_out(bit_out), .bit_valid(bit_valid),
        .preamble(preamble), .tari(tari), .rtcal(rtcal), .trcal(trcal),
        .rx_overflow_reset(rx_overflow_reset), .frame_err(frame_err), .rng_bit(rng_bit), .busy(busy)
    );

    pie_rx_gen2 #(.CNT_W(6)) dut6 (
        .clk(clk), .reset(reset), .demodin(demodin), .bit_out(bo6), .bit_valid(bv6),
        .preamble(pr6), .tari(ta6), .rtcal(rt6), .trcal(tr6),
        .rx_overflow_reset(eof6), .frame_err(err6), .rng_bit(rng6), .busy(busy6)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(int kind, int b);
        ev_t e;
        e = '{kind, b, m_ta, m_rt, m_tr, m_pre};
        exp_q.push_back(e);
    endtask

    // Frame-level model: kind 0 = bit, 1 = end of frame, 2 = framing error.
    task automatic model_frame(int dl, bit with_eof);
        if (dl < 8) return;
        m_ta = iv_q[0];
        if (iv_q[1] <= m_ta) begin
            push_ev(2, 0);
            return;
        end
        m_rt = iv_q[1];
        for (int i = 2; i < iv_q.size(); i++) begin
            if (i == 2) m_pre = iv_q[i] > m_rt ? 1 : 0;
            if (i == 2 && m_pre == 1) m_tr = iv_q[i];
            else push_ev(0, iv_q[i] > m_rt / 2 ? 1 : 0);
        end
        if (with_eof) push_ev(1, 0);
    endtask

    task automatic set_iv(int n, int a, int b, int c, int d, int e, int f);
        int t[6];
        t = '{a, b, c, d, e, f};
        iv_q.delete();
        for (int i = 0; i < n; i++) iv_q.push_back(t[i]);
    endtask

    task automatic drive(bit v, int n);
        repeat (n) begin
            demodin = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(int dl, int tail);
        drive(1'b1, 20);
        drive(1'b0, dl);
        foreach (iv_q[i]) begin
            drive(1'b1, iv_q[i] - PW);
            drive(1'b0, PW);
        end
        drive(1'b1, tail);
    endtask

    task automatic chk_zero(string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_bit_valid"}, bit_valid, 0);
        chk({name, "_bit_out"}, bit_out, 0);
        chk({name, "_eof"}, rx_overflow_reset, 0);
        chk({name, "_frame_err"}, frame_err, 0);
        chk({name, "_preamble"}, preamble, 0);
        chk({name, "_tari"}, tari, 0);
        chk({name, "_rtcal"}, rtcal, 0);
        chk({name, "_trcal"}, trcal, 0);
        chk({name, "_rng_bit"}, rng_bit, 0);
    endtask

    always @(negedge clk) begin : cmp
        int  kind;
        ev_t e;
        if (!reset && (bit_valid || rx_overflow_reset || frame_err)) begin
            kind = bit_valid ? 0 : (rx_overflow_reset ? 1 : 2);
            chk("pulse_exclusive", int'(bit_valid) + int'(rx_overflow_reset) + int'(frame_err), 1);
            if (exp_q.size() == 0) chk("unexpected_pulse_kind", kind, -1);
            else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                if (kind == 0) begin
                    chk("bit_out", bit_out, e.b);
                    bit_log.push_back(int'(bit_out));
                    bv_cyc <= cyc;
                end
                if (kind == 1) begin
                    chk("eof_gap", cyc - bv_cyc, e.rt + 1);
                    last_gap <= cyc - bv_cyc;
                end
                chk("tari", tari, e.ta);
                chk("rtcal", rtcal, e.rt);
                chk("trcal", trcal, e.tr);
                chk("preamble", preamble, e.pre);
            end
        end
    end

    initial begin
        int k;
        drive(1'b1, 5);
        chk_zero("reset");
        reset = 1'b0;
        drive(1'b1, 10);

        set_iv(6, 20, 50, 100, 20, 35, 25);
        bit_log.delete();
        model_frame(12, 1'b1);
        send_frame(12, 70);
        chk("query_drained", exp_q.size(), 0);
        chk("query_tari", tari, 20);
        chk("query_rtcal", rtcal, 50);
        chk("query_trcal", trcal, 100);
        chk("query_preamble", preamble, 1);
        chk("query_bits", bit_log.size() == 3 ? bit_log[0] * 4 + bit_log[1] * 2 + bit_log[2] : -1, 2);
        chk("query_eof_gap", last_gap, 51);
        chk("query_idle", busy, 0);

        set_iv(3, 20, 50, 30, 0, 0, 0);
        bit_log.delete();
        model_frame(12, 1'b1);
        send_frame(12, 70);
        chk("fsync_drained", exp_q.size(), 0);
        chk("fsync_preamble", preamble, 0);
        chk("fsync_trcal_held", trcal, 100);
        chk("fsync_first_bit", bit_log.size() == 1 ? bit_log[0] : -1, 1);

        drive(1'b0, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1);
            chk("glitch1_busy", busy, 0);
        end
        drive(1'b0, 5);
        chk("glitch5_in_delim", busy, 1);
        drive(1'b1, 20);
        chk("glitch5_idle", busy, 0);
        chk("glitch5_drained", exp_q.size(), 0);

        set_iv(2, 20, 18, 0, 0, 0, 0);
        model_frame(12, 1'b1);
        send_frame(12, 70);
        chk("badrt_drained", exp_q.size(), 0);
        chk("badrt_rtcal_held", rtcal, 50);
        chk("badrt_idle", busy, 0);

        set_iv(4, 20, 50, 100, 35, 0, 0);
        model_frame(12, 1'b0);
        send_frame(12, 8);
        chk("midbits_busy", busy, 1);
        chk("midbits_drained", exp_q.size(), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midreset");
        reset = 1'b0;
        m_ta = 0; m_rt = 0; m_tr = 0; m_pre = 0;
        drive(1'b1, 70);
        chk("midreset_no_eof", exp_q.size(), 0);

        reset = 1'b1;
        drive(1'b1, 3);
        reset = 1'b0;
        drive(1'b1, 10);
        drive(1'b0, 12);
        demodin = 1'b1;
        k = 0;
        while (!err6 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("sat_latency", k, 68);
        @(posedge clk);
        #1;
        chk("sat_err_single", err6, 0);
        chk("sat_idle", busy6, 0);
        chk("sat_wide_no_pulse", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
